uart_baud_detect: RTL and testbench
===================================

UART_BAUD_DETECT -- requirements
Module: uart_baud_detect

Interface
REQ-001 The block SHALL have parameter MAX_CNT, default 65535: saturation limit of the low-pulse measurement counter.
REQ-002 The block SHALL have parameter IDLE_CYC, default 16: consecutive high samples required before arming.
REQ-003 The block SHALL have parameter MIN_CNT, default 4: shortest accepted low pulse in cycles; shorter pulses are glitches.
REQ-004 The block SHALL have parameter W, default $clog2(MAX_CNT+1): measurement width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port en, input, 1 bit: detector enable.
REQ-008 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-009 The block SHALL have port bit_cnt, output, W bits: last accepted low-pulse length in clk cycles.
REQ-010 The block SHALL have port valid, output, 1 bit: one-cycle pulse when bit_cnt is updated.
REQ-011 The block SHALL have port err_short, output, 1 bit: one-cycle pulse on a rejected glitch.
REQ-012 The block SHALL have port err_sat, output, 1 bit: one-cycle pulse on a saturated or stuck-low measurement.
REQ-013 The block SHALL have port busy, output, 1 bit: high in ARMED and MEASURE.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer (rx_s), with 2 cycles of latency from rx to rx_s.
REQ-015 The FSM SHALL have states OFF, WAIT_IDLE, ARMED and MEASURE, all registered.
REQ-016 In OFF, the FSM SHALL go to WAIT_IDLE when en=1 and clear the idle counter.
REQ-017 In WAIT_IDLE, rx_s=1 SHALL increment the idle counter, saturating at IDLE_CYC.
REQ-018 In WAIT_IDLE, rx_s=0 SHALL clear the idle counter.
REQ-019 In WAIT_IDLE, the FSM SHALL go to ARMED in the cycle after the idle counter reaches IDLE_CYC.
REQ-020 In ARMED, rx_s=0 SHALL load the measurement counter with 1 and go to MEASURE.
REQ-021 In MEASURE, rx_s=0 with cnt<MAX_CNT SHALL increment cnt.
REQ-022 In MEASURE, rx_s=0 with cnt==MAX_CNT SHALL pulse err_sat next cycle and go to WAIT_IDLE with the idle counter cleared; bit_cnt SHALL be unchanged.
REQ-023 In MEASURE, rx_s=1 with cnt>=MIN_CNT SHALL, next cycle, set bit_cnt=cnt, pulse valid and go to WAIT_IDLE with the idle counter cleared.
REQ-024 In MEASURE, rx_s=1 with cnt<MIN_CNT SHALL pulse err_short next cycle and go to WAIT_IDLE; bit_cnt SHALL be unchanged.
REQ-025 Measured value SHALL equal the number of consecutive low rx_s samples; a low pulse of N cycles on rx gives bit_cnt=N.
REQ-026 valid, err_short and err_sat SHALL be mutually exclusive and each high for exactly one cycle per event.
REQ-027 en=0 in any state SHALL force OFF next cycle, with no valid or error pulse, and SHALL clear the counters; bit_cnt SHALL hold.
REQ-028 en=0 SHALL take priority over every other transition in the same cycle.
REQ-029 bit_cnt SHALL hold its last accepted value until the next accepted measurement.
REQ-030 All counters SHALL saturate and never wrap.
REQ-031 Comparisons SHALL be unsigned at width W.

Reset
REQ-032 When rst=1 at a clock edge, the FSM SHALL enter OFF and the idle and measurement counters SHALL clear.
REQ-033 When rst=1 at a clock edge, bit_cnt SHALL be 0; valid, err_short, err_sat and busy SHALL be 0; both synchronizer flops SHALL be 1.
REQ-034 rst SHALL take priority over en, including during MEASURE; the in-flight measurement SHALL be discarded with no pulse.

Verification (bench parameters: MAX_CNT=255, IDLE_CYC=16, MIN_CNT=4)
REQ-035 The bench SHALL drive en=1, rx high 20 cycles, rx low 100 cycles, then rx high, and SHALL require valid for 1 cycle with bit_cnt=100, busy=0 afterwards, and no error pulse.
REQ-036 The bench SHALL drive rx high 20 cycles then rx low 3 cycles, and SHALL require err_short for 1 cycle, bit_cnt unchanged, and no valid.
REQ-037 The bench SHALL drive rx high 20 cycles then rx low 400 cycles, and SHALL require err_sat for 1 cycle after 255 low samples, no re-arm while rx is low, and re-arm 16 cycles after rx returns high.
REQ-038 The bench SHALL drive rx high 10 cycles, low 1 cycle, then high 10 cycles, and SHALL require the idle counter to restart, busy to stay 0 until 16 consecutive high samples, and no pulses.
REQ-039 The bench SHALL drop en to 0 at the 50th cycle of a 100-cycle low pulse, and SHALL require OFF next cycle, no pulses, and bit_cnt keeping its previous value.
REQ-040 The bench SHALL assert rst for 1 cycle during MEASURE, and SHALL require all outputs 0 next cycle and a new measurement only after a fresh 16-cycle idle.

Source files
------------

// File: rtl/uart_baud_detect.sv
// uart_baud_detect
// Measures the length of the first low pulse on an idle-high serial line,
// typically a start bit, in clk cycles, so software can derive the baud rate.
// The line must be idle high for IDLE_CYC consecutive synchronized samples
// before the detector arms. Low pulses shorter than MIN_CNT are rejected as
// glitches. Pulses that reach MAX_CNT are reported as saturated.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous reset, active high
//   en         detector enable; low forces OFF and clears counters
//   rx         asynchronous serial input, idle high
//   bit_cnt    last accepted low-pulse length (held between measurements)
//   valid      one-cycle pulse when bit_cnt is updated
//   err_short  one-cycle pulse on a rejected glitch
//   err_sat    one-cycle pulse on a saturated or stuck-low measurement
//   busy       high while ARMED or MEASURE
//
// state     | meaning
// ----------+--------------------------------------------------------------
// OFF       | disabled, counters cleared
// WAIT_IDLE | counting consecutive high samples of rx_s up to IDLE_CYC
// ARMED     | line proven idle, waiting for the falling edge
// MEASURE   | counting low samples of rx_s
module uart_baud_detect #(
    parameter int MAX_CNT  = 65535,
    parameter int IDLE_CYC = 16,
    parameter int MIN_CNT  = 4,
    parameter int W        = $clog2(MAX_CNT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         rx,
    output logic [W-1:0] bit_cnt,
    output logic         valid,
    output logic         err_short,
    output logic         err_sat,
    output logic         busy
);

    localparam int IW = $clog2(IDLE_CYC + 1);
    localparam logic [W-1:0]  CNT_MAX  = W'(MAX_CNT);
    localparam logic [W-1:0]  CNT_MIN  = W'(MIN_CNT);
    localparam logic [IW-1:0] IDLE_TGT = IW'(IDLE_CYC);

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        WAIT_IDLE = 2'd1,
        ARMED     = 2'd2,
        MEASURE   = 2'd3
    } state_t;

    state_t        state;
    logic          rx_m;
    logic          rx_s;
    logic [IW-1:0] idle_cnt;
    logic [W-1:0]  cnt;

    // Two-flop synchronizer; resets to the idle level so reset never looks
    // like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= OFF;
            idle_cnt  <= '0;
            cnt       <= '0;
            bit_cnt   <= '0;
            valid     <= 1'b0;
            err_short <= 1'b0;
            err_sat   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            err_short <= 1'b0;
            err_sat   <= 1'b0;

            if (!en) begin
                state    <= OFF;
                idle_cnt <= '0;
                cnt      <= '0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    OFF: begin
                        state    <= WAIT_IDLE;
                        idle_cnt <= '0;
                        busy     <= 1'b0;
                    end

                    WAIT_IDLE: begin
                        // Once the target is reached we leave on the next
                        // edge, so the increment branch only ever runs below
                        // the target and the counter cannot pass it.
                        if (idle_cnt == IDLE_TGT) begin
                            state <= ARMED;
                            busy  <= 1'b1;
                        end else if (rx_s) begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end else begin
                            idle_cnt <= '0;
                        end
                    end

                    ARMED: begin
                        // The sample that triggers the move is itself the
                        // first low sample, hence the load of 1.
                        if (!rx_s) begin
                            cnt   <= W'(1);
                            state <= MEASURE;
                        end
                    end

                    MEASURE: begin
                        if (!rx_s) begin
                            if (cnt < CNT_MAX) begin
                                cnt <= cnt + 1'b1;
                            end else begin
                                err_sat  <= 1'b1;
                                state    <= WAIT_IDLE;
                                idle_cnt <= '0;
                                cnt      <= '0;
                                busy     <= 1'b0;
                            end
                        end else begin
                            if (cnt >= CNT_MIN) begin
                                bit_cnt <= cnt;
                                valid   <= 1'b1;
                            end else begin
                                err_short <= 1'b1;
                            end
                            state    <= WAIT_IDLE;
                            idle_cnt <= '0;
                            cnt      <= '0;
                            busy     <= 1'b0;
                        end
                    end

                    default: begin
                        state <= OFF;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_detect.sv
// Testbench for uart_baud_detect with MAX_CNT=255, IDLE_CYC=16, MIN_CNT=4.
// Directed scenarios followed by random line activity; every cycle the DUT
// outputs are compared against a run-length model of the line.
module tb_uart_baud_detect;

    localparam int MAX_CNT  = 255;
    localparam int IDLE_CYC = 16;
    localparam int MIN_CNT  = 4;
    localparam int W        = $clog2(MAX_CNT + 1);

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         rx;
    logic [W-1:0] bit_cnt;
    logic         valid;
    logic         err_short;
    logic         err_sat;
    logic         busy;

    always #5 clk = ~clk;

    uart_baud_detect #(
        .MAX_CNT  (MAX_CNT),
        .IDLE_CYC (IDLE_CYC),
        .MIN_CNT  (MIN_CNT),
        .W        (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rx        (rx),
        .bit_cnt   (bit_cnt),
        .valid     (valid),
        .err_short (err_short),
        .err_sat   (err_sat),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model of the line as seen by the detector:
    //   two-sample delay line, a count of consecutive quiet (high) samples,
    //   a ready flag once the quiet requirement is met, and the length of the
    //   low run being measured (0 when not measuring).
    bit m_d1, m_d2;
    bit m_on;
    bit m_ready;
    int m_quiet;
    int m_low;
    int m_bitcnt;
    bit m_valid, m_short, m_sat;

    // Observed event tallies, cleared per scenario.
    int n_valid, n_short, n_sat, n_busy;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit e, input bit r, input bit rs);
        bit s;
        s = m_d2;
        m_valid = 1'b0;
        m_short = 1'b0;
        m_sat   = 1'b0;
        if (rs) begin
            m_d1 = 1'b1; m_d2 = 1'b1;
            m_on = 1'b0; m_ready = 1'b0;
            m_quiet = 0; m_low = 0; m_bitcnt = 0;
            return;
        end
        m_d2 = m_d1;
        m_d1 = r;
        if (!e) begin
            m_on = 1'b0; m_ready = 1'b0; m_quiet = 0; m_low = 0;
        end else if (!m_on) begin
            m_on = 1'b1; m_quiet = 0;
        end else if (m_low > 0) begin
            if (!s) begin
                if (m_low < MAX_CNT) m_low++;
                else begin
                    m_sat = 1'b1; m_low = 0; m_quiet = 0;
                end
            end else begin
                if (m_low >= MIN_CNT) begin
                    m_bitcnt = m_low; m_valid = 1'b1;
                end else begin
                    m_short = 1'b1;
                end
                m_low = 0; m_quiet = 0;
            end
        end else if (m_ready) begin
            if (!s) begin
                m_ready = 1'b0; m_low = 1;
            end
        end else if (m_quiet >= IDLE_CYC) begin
            m_ready = 1'b1;
        end else if (s) begin
            m_quiet++;
        end else begin
            m_quiet = 0;
        end
    endtask

    task automatic tick(input bit e, input bit r, input bit rs);
        en  = e;
        rx  = r;
        rst = rs;
        model_step(e, r, rs);
        @(posedge clk);
        @(negedge clk);
        check_val("bit_cnt",   bit_cnt,   m_bitcnt);
        check_val("valid",     valid,     m_valid);
        check_val("err_short", err_short, m_short);
        check_val("err_sat",   err_sat,   m_sat);
        check_val("busy",      busy,      (m_ready || m_low > 0));
        if (valid)     n_valid++;
        if (err_short) n_short++;
        if (err_sat)   n_sat++;
        if (busy)      n_busy++;
    endtask

    task automatic run(input bit e, input bit r, input int n);
        for (int i = 0; i < n; i++) tick(e, r, 1'b0);
    endtask

    task automatic clear_tally();
        n_valid = 0; n_short = 0; n_sat = 0; n_busy = 0;
    endtask

    int  rearm_at;
    int  sat_at;
    int  seg_len;
    bit  lvl;
    bit  e_r;
    bit  rst_r;

    initial begin
        en  = 1'b0;
        rx  = 1'b1;
        rst = 1'b1;

        // Reset state
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        check_val("rst_bit_cnt", bit_cnt, 0);
        check_val("rst_busy",    busy,    0);

        // Normal 100-cycle low pulse
        clear_tally();
        run(1'b1, 1'b1, 20);
        check_val("armed_after_idle", busy, 1);
        run(1'b1, 1'b0, 100);
        run(1'b1, 1'b1, 20);
        check_val("s1_valid_cnt", n_valid, 1);
        check_val("s1_short_cnt", n_short, 0);
        check_val("s1_sat_cnt",   n_sat,   0);
        check_val("s1_bit_cnt",   bit_cnt, 100);

        // 3-cycle glitch
        clear_tally();
        run(1'b1, 1'b1, 20);
        run(1'b1, 1'b0, 3);
        run(1'b1, 1'b1, 10);
        check_val("s2_short_cnt", n_short, 1);
        check_val("s2_valid_cnt", n_valid, 0);
        check_val("s2_bit_cnt",   bit_cnt, 100);

        // Stuck low: saturates after 255 low samples, re-arms after idle
        run(1'b1, 1'b1, 20);
        clear_tally();
        sat_at = -1;
        for (int i = 0; i < 400; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (err_sat && sat_at < 0) sat_at = i;
        end
        // 2 sync cycles, then 255 low samples counted, pulse on the next edge
        check_val("s3_sat_at",   sat_at,  257);
        check_val("s3_sat_cnt",  n_sat,   1);
        check_val("s3_valid",    n_valid, 0);
        check_val("s3_busy_low", busy,    0);
        check_val("s3_bit_cnt",  bit_cnt, 100);
        rearm_at = -1;
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            if (busy && rearm_at < 0) rearm_at = i;
        end
        // 2 sync cycles + 16 quiet samples, armed on the following edge
        check_val("s3_rearm_at", rearm_at, 18);

        // One-cycle dip restarts the idle count
        run(1'b0, 1'b1, 2);
        clear_tally();
        run(1'b1, 1'b1, 10);
        run(1'b1, 1'b0, 1);
        run(1'b1, 1'b1, 10);
        check_val("s4_busy_cycles", n_busy, 0);
        check_val("s4_pulses", n_valid + n_short + n_sat, 0);
        run(1'b1, 1'b1, 20);
        check_val("s4_armed", busy, 1);

        // Enable dropped mid-measurement
        clear_tally();
        run(1'b1, 1'b0, 49);
        tick(1'b0, 1'b0, 1'b0);
        check_val("s5_busy_off", busy, 0);
        run(1'b0, 1'b0, 50);
        check_val("s5_pulses",  n_valid + n_short + n_sat, 0);
        check_val("s5_bit_cnt", bit_cnt, 100);
        run(1'b1, 1'b1, 25);

        // Reset during measurement
        run(1'b1, 1'b0, 30);
        check_val("s6_measuring", busy, 1);
        clear_tally();
        tick(1'b1, 1'b0, 1'b1);
        check_val("s6_rst_bit_cnt", bit_cnt,   0);
        check_val("s6_rst_valid",   valid,     0);
        check_val("s6_rst_short",   err_short, 0);
        check_val("s6_rst_sat",     err_sat,   0);
        check_val("s6_rst_busy",    busy,      0);
        run(1'b1, 1'b0, 10);
        check_val("s6_no_busy", n_busy, 0);
        check_val("s6_pulses",  n_valid + n_short + n_sat, 0);
        run(1'b1, 1'b1, 25);
        run(1'b1, 1'b0, 50);
        run(1'b1, 1'b1, 10);
        check_val("s6_valid_cnt", n_valid, 1);
        check_val("s6_bit_cnt",   bit_cnt, 50);

        // Random line activity
        lvl = 1'b1;
        for (int ep = 0; ep < 80; ep++) begin
            if ($urandom_range(0, 9) < 8) lvl = ~lvl;
            case ($urandom_range(0, 3))
                0:       seg_len = $urandom_range(1, 6);
                1:       seg_len = $urandom_range(7, 40);
                2:       seg_len = $urandom_range(240, 270);
                default: seg_len = $urandom_range(20, 120);
            endcase
            for (int i = 0; i < seg_len; i++) begin
                e_r   = ($urandom_range(0, 199) != 0);
                rst_r = ($urandom_range(0, 399) == 0);
                tick(e_r, lvl, rst_r);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
